bsg_mesh_endpoint_credit: RTL

- Local-port endpoint that sits on the P (proc) port of a mesh router.
- Packetizes client requests into router flits (dest coords in low bits, then src coords, then payload) and injects them into the router P input.
- Ejects flits from the router P output and presents them to the client as responses.
- Bounds outstanding requests with a credit counter: each accepted request consumes a credit; each ejected response returns one.

---
 rtl/bsg_mesh_endpoint_credit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bsg_mesh_endpoint_credit.sv
// Mesh P-port endpoint: packetizes client requests into router flits, ejects
// router flits as client responses, and bounds outstanding requests with credits.
module bsg_mesh_endpoint_credit #(
  parameter int width_p        = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int max_out_p      = 4,
  localparam int payload_width_lp = width_p - 2*(x_cord_width_p + y_cord_width_p),
  localparam int credit_width_lp  = $clog2(max_out_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [x_cord_width_p-1:0]   my_x_i,
  input  logic [y_cord_width_p-1:0]   my_y_i,
  input  logic                        req_v_i,
  input  logic [x_cord_width_p-1:0]   req_x_i,
  input  logic [y_cord_width_p-1:0]   req_y_i,
  input  logic [payload_width_lp-1:0] req_payload_i,
  output logic                        req_ready_and_o,
  output logic [width_p-1:0]          link_data_o,
  output logic                        link_v_o,
  input  logic                        link_yumi_i,
  input  logic [width_p-1:0]          link_data_i,
  input  logic                        link_v_i,
  output logic                        link_ready_and_o,
  output logic                        resp_v_o,
  output logic [x_cord_width_p-1:0]   resp_src_x_o,
  output logic [y_cord_width_p-1:0]   resp_src_y_o,
  output logic [payload_width_lp-1:0] resp_payload_o,
  input  logic                        resp_yumi_i,
  output logic [credit_width_lp-1:0]  credits_o
);

  localparam int lp_cordW = x_cord_width_p + y_cord_width_p;
  localparam logic [credit_width_lp-1:0] lp_maxCredits = credit_width_lp'(max_out_p);

  logic [width_p-1:0]         r_txMem [2];
  logic                       r_txWrPtr;
  logic                       r_txRdPtr;
  logic [1:0]                 r_txCount;
  logic [width_p-1:0]         r_rxMem [2];
  logic                       r_rxWrPtr;
  logic                       r_rxRdPtr;
  logic [1:0]                 r_rxCount;
  logic [credit_width_lp-1:0] r_credits;

  logic               w_txFull;
  logic               w_txEmpty;
  logic               w_txEnq;
  logic               w_txDeq;
  logic [width_p-1:0] w_txFlit;
  logic               w_rxFull;
  logic               w_rxEmpty;
  logic               w_rxEnq;
  logic               w_rxDeq;
  logic [width_p-1:0] w_rxHead;
  logic               w_credInc;
  logic               w_credDec;

  // Handshake outputs are gated by reset_i so they read 0 during reset even
  // before the first reset edge has cleared the FIFO state.
  assign w_txFull        = (r_txCount == 2'd2);
  assign w_txEmpty       = (r_txCount == 2'd0);
  assign req_ready_and_o = reset_i & ~w_txFull & (r_credits != '0);
  assign w_txEnq         = req_v_i & req_ready_and_o;
  assign link_v_o        = reset_i & ~w_txEmpty;
  assign w_txDeq         = link_yumi_i & link_v_o;
  assign link_data_o     = r_txMem[r_txRdPtr];
  assign w_txFlit        = {req_payload_i, my_y_i, my_x_i, req_y_i, req_x_i};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_txWrPtr <= 1'b0;
      r_txRdPtr <= 1'b0;
      r_txCount <= 2'd0;
    end else begin
      if (w_txEnq) r_txWrPtr <= ~r_txWrPtr;
      if (w_txDeq) r_txRdPtr <= ~r_txRdPtr;
      r_txCount <= r_txCount + 2'(w_txEnq) - 2'(w_txDeq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_txEnq) r_txMem[r_txWrPtr] <= w_txFlit;
  end

  assign w_rxFull         = (r_rxCount == 2'd2);
  assign w_rxEmpty        = (r_rxCount == 2'd0);
  assign link_ready_and_o = reset_i & ~w_rxFull;
  assign w_rxEnq          = link_v_i & link_ready_and_o;
  assign resp_v_o         = reset_i & ~w_rxEmpty;
  assign w_rxDeq          = resp_yumi_i & resp_v_o;
  assign w_rxHead         = r_rxMem[r_rxRdPtr];
  assign resp_src_x_o     = w_rxHead[lp_cordW +: x_cord_width_p];
  assign resp_src_y_o     = w_rxHead[lp_cordW + x_cord_width_p +: y_cord_width_p];
  assign resp_payload_o   = w_rxHead[width_p-1 -: payload_width_lp];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rxWrPtr <= 1'b0;
      r_rxRdPtr <= 1'b0;
      r_rxCount <= 2'd0;
    end else begin
      if (w_rxEnq) r_rxWrPtr <= ~r_rxWrPtr;
      if (w_rxDeq) r_rxRdPtr <= ~r_rxRdPtr;
      r_rxCount <= r_rxCount + 2'(w_rxEnq) - 2'(w_rxDeq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_rxEnq) r_rxMem[r_rxWrPtr] <= link_data_i;
  end

  // A surplus response at full credits is a protocol error; the count saturates.
  assign w_credDec = w_txEnq;
  assign w_credInc = w_rxEnq;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_credits <= lp_maxCredits;
    end else if (w_credDec && !w_credInc) begin
      r_credits <= r_credits - 1'b1;
    end else if (w_credInc && !w_credDec && (r_credits != lp_maxCredits)) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  assign credits_o = r_credits;

  a_creditOverflow: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(w_credInc && !w_credDec && (r_credits == lp_maxCredits)));
  a_destIsSelf: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(w_txEnq && (req_x_i == my_x_i) && (req_y_i == my_y_i)));
  a_linkYumiIdle: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(link_yumi_i && !link_v_o));
  a_respYumiIdle: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(resp_yumi_i && !resp_v_o));
  // Flits ejected on the P port must be addressed to this node.
  a_ejectDest: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(resp_v_o && ((w_rxHead[x_cord_width_p-1:0] != my_x_i) ||
                   (w_rxHead[x_cord_width_p +: y_cord_width_p] != my_y_i))));

endmodule
